// File: rtl/ex_muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv_unit_pkg
//  Description : Shared encodings for the iterative RV32M multiply/divide
//                unit: M-extension funct3 opcodes, FSM state codes and
//                operand-signedness helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package ex_muldiv_unit_pkg;

   typedef logic [2:0] op_t;

   // M-extension funct3 encodings
   localparam op_t OP_MUL    = 3'b000;
   localparam op_t OP_MULH   = 3'b001;
   localparam op_t OP_MULHSU = 3'b010;
   localparam op_t OP_MULHU  = 3'b011;
   localparam op_t OP_DIV    = 3'b100;
   localparam op_t OP_DIVU   = 3'b101;
   localparam op_t OP_REM    = 3'b110;
   localparam op_t OP_REMU   = 3'b111;

   // FSM state encodings
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_FIN  = 2'd2;

   // rs1 is treated as a signed value by these ops
   function automatic logic op_signed_a(input op_t op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   // rs2 is treated as a signed value by these ops
   function automatic logic op_signed_b(input op_t op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv_unit_if
//  Description : Request/response bundle between the EX stage and the
//                multiply/divide unit.
//    start         - request, accepted only while busy is low
//    op            - M-ext funct3
//    operand_a/b   - rs1 / rs2 values
//    dest_addr_in  - destination register tag of the request
//    flush         - abort in-flight op
//    busy          - op in flight (EX stall)
//    done          - one-cycle completion pulse
//    result        - result, held until next done
//    dest_addr_out - tag of the completed op, held with result
//  Revision    : 1.0 - initial release
// ============================================================================
interface ex_muldiv_unit_if
   import ex_muldiv_unit_pkg::*;
#(
   parameter int XLEN = 32
);
   logic            start;
   op_t             op;
   logic [XLEN-1:0] operand_a;
   logic [XLEN-1:0] operand_b;
   logic [4:0]      dest_addr_in;
   logic            flush;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;
   logic [4:0]      dest_addr_out;

   modport master (
      output start, op, operand_a, operand_b, dest_addr_in, flush,
      input  busy, done, result, dest_addr_out
   );

   modport slave (
      input  start, op, operand_a, operand_b, dest_addr_in, flush,
      output busy, done, result, dest_addr_out
   );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv_unit_muldiv_iter_step.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_iter_step
//  Description : Combinational single-iteration datapath shared by multiply
//                and divide. The 2*XLEN accumulator holds
//                  multiply : {partial product high, multiplier bits left}
//                  divide   : {partial remainder, dividend/quotient bits}
//    acc      - current accumulator
//    b_mag    - divisor/multiplicand magnitude (XLEN+1 bits, MSB zero)
//    is_div   - select restoring-divide step instead of add-shift
//    acc_next - accumulator after one iteration
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_iter_step #(
   parameter int XLEN = 32
) (
   input  logic [2*XLEN-1:0] acc,
   input  logic [XLEN:0]     b_mag,
   input  logic              is_div,
   output logic [2*XLEN-1:0] acc_next
);
   logic [XLEN:0]     w_sum;
   logic [2*XLEN-1:0] w_acc_mul;
   logic [XLEN:0]     w_rem_sh;
   logic [XLEN:0]     w_trial;
   logic              w_fits;
   logic [2*XLEN-1:0] w_acc_div;

   // Add-shift: add b into the high half when the current multiplier LSB is
   // set, then shift the whole accumulator right by one (carry enters top).
   assign w_sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? b_mag : '0);
   assign w_acc_mul = {w_sum, acc[XLEN-1:1]};

   // Restoring divide: shift next dividend bit into the remainder and try
   // subtracting b. The shifted remainder is below 2*b, so the trial result
   // lies in (-b, b) and its MSB is the borrow.
   assign w_rem_sh  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
   assign w_trial   = w_rem_sh - b_mag;
   assign w_fits    = ~w_trial[XLEN];
   assign w_acc_div = {(w_fits ? w_trial[XLEN-1:0] : w_rem_sh[XLEN-1:0]),
                       acc[XLEN-2:0], w_fits};

   assign acc_next  = is_div ? w_acc_div : w_acc_mul;

endmodule
`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv_unit
//  Description : Iterative RV32M multiply/divide unit for the EX stage,
//                one bit per cycle on unsigned magnitudes with sign fix-up
//                at the end. Divide-by-zero and MIN/-1 overflow complete
//                in one cycle without leaving IDLE.
//    clk - clock, rising edge
//    rst - asynchronous active-high reset
//    bus - request/response bundle (slave side)
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit
   import ex_muldiv_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   ex_muldiv_unit_if.slave bus
);
   localparam int              CNT_W     = $clog2(XLEN);
   localparam logic [XLEN-1:0] C_MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(XLEN - 1);

   logic [1:0]        r_state;
   logic [1:0]        w_state_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [2*XLEN-1:0] r_acc;
   logic [XLEN:0]     r_b_mag;
   op_t               r_op;
   logic [4:0]        r_tag;
   logic              r_neg_main;   // negate product / quotient
   logic              r_neg_rem;    // negate remainder
   logic              r_done;
   logic [XLEN-1:0]   r_result;
   logic [4:0]        r_dest;

   logic              w_busy;
   logic              w_accept;
   logic              w_fast;
   logic              w_fast_done;
   logic              w_launch;
   logic              w_step;
   logic              w_finish;

   // ---------------- request decode ----------------
   logic [XLEN:0]     w_a_ext, w_b_ext, w_a_mag, w_b_mag;
   logic              w_a_neg, w_b_neg;
   logic              w_b_zero, w_ovf;
   logic [XLEN-1:0]   w_fast_result;

   // XLEN+1-bit sign extension keeps -MIN_INT exact
   assign w_a_ext  = {op_signed_a(bus.op) & bus.operand_a[XLEN-1], bus.operand_a};
   assign w_b_ext  = {op_signed_b(bus.op) & bus.operand_b[XLEN-1], bus.operand_b};
   assign w_a_neg  = w_a_ext[XLEN];
   assign w_b_neg  = w_b_ext[XLEN];
   assign w_a_mag  = w_a_neg ? -w_a_ext : w_a_ext;
   assign w_b_mag  = w_b_neg ? -w_b_ext : w_b_ext;

   assign w_b_zero = (bus.operand_b == '0);
   assign w_ovf    = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                     (bus.operand_a == C_MIN_INT) && (bus.operand_b == '1);
   assign w_fast   = bus.op[2] && (w_b_zero || w_ovf);

   always_comb begin
      w_fast_result = '1;
      if (w_b_zero) begin
         w_fast_result = bus.op[1] ? bus.operand_a : '1;
      end else begin
         w_fast_result = bus.op[1] ? '0 : C_MIN_INT;
      end
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_next = r_state;
      if (bus.flush) begin
         w_state_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: if (bus.start && !w_fast) w_state_next = ST_CALC;
            ST_CALC: if (r_cnt == C_LAST)      w_state_next = ST_FIN;
            ST_FIN:                            w_state_next = ST_IDLE;
            default:                           w_state_next = ST_IDLE;
         endcase
      end
   end

   // ---------------- FSM: outputs / control ----------------
   always_comb begin
      w_busy      = (r_state != ST_IDLE);
      w_accept    = (r_state == ST_IDLE) && bus.start && !bus.flush;
      w_fast_done = w_accept && w_fast;
      w_launch    = w_accept && !w_fast;
      w_step      = (r_state == ST_CALC) && !bus.flush;
      w_finish    = (r_state == ST_FIN)  && !bus.flush;
   end

   // ---------------- iteration datapath ----------------
   logic [2*XLEN-1:0] w_acc_next;

   muldiv_iter_step #(
      .XLEN     (XLEN)
   ) u_step (
      .acc      (r_acc),
      .b_mag    (r_b_mag),
      .is_div   (r_op[2]),
      .acc_next (w_acc_next)
   );

   // ---------------- sign correction and result select ----------------
   logic [2*XLEN-1:0] w_prod;
   logic [XLEN-1:0]   w_quo, w_rem, w_final;

   assign w_prod = r_neg_main ? -r_acc : r_acc;
   assign w_quo  = r_acc[XLEN-1:0];
   assign w_rem  = r_acc[2*XLEN-1:XLEN];

   always_comb begin
      w_final = '0;
      case (r_op)
         OP_MUL:                       w_final = w_prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              w_final = r_neg_main ? -w_quo : w_quo;
         default:                      w_final = r_neg_rem ? -w_rem : w_rem;
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt      <= '0;
         r_acc      <= '0;
         r_b_mag    <= '0;
         r_op       <= OP_MUL;
         r_tag      <= '0;
         r_neg_main <= 1'b0;
         r_neg_rem  <= 1'b0;
         r_done     <= 1'b0;
         r_result   <= '0;
         r_dest     <= '0;
      end else begin
         r_done <= 1'b0;
         if (w_fast_done) begin
            r_result <= w_fast_result;
            r_dest   <= bus.dest_addr_in;
            r_done   <= 1'b1;
         end
         if (w_launch) begin
            // Magnitude MSB is always zero, so the top word starts cleared
            r_acc      <= {{(XLEN-1){1'b0}}, w_a_mag};
            r_b_mag    <= w_b_mag;
            r_op       <= bus.op;
            r_tag      <= bus.dest_addr_in;
            r_neg_main <= w_a_neg ^ w_b_neg;
            r_neg_rem  <= w_a_neg;
            r_cnt      <= '0;
         end
         if (w_step) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_finish) begin
            r_result <= w_final;
            r_dest   <= r_tag;
            r_done   <= 1'b1;
         end
      end
   end

   assign bus.busy          = w_busy;
   assign bus.done          = r_done;
   assign bus.result        = r_result;
   assign bus.dest_addr_out = r_dest;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_muldiv_unit
//  Description : Self-checking bench for ex_muldiv_unit (XLEN=32). Directed
//                vectors carry hand-computed results; an arithmetic model
//                predicts result, tag and completion cycle, and a compare
//                process checks busy/done/result/tag on every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_unit;
   import ex_muldiv_unit_pkg::*;

   localparam int XLEN = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;

   ex_muldiv_unit_if #(.XLEN(XLEN)) mif ();

   ex_muldiv_unit #(.XLEN(XLEN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (mif)
   );

   always #5 clk = ~clk;

   // index of the most recent rising edge
   int e_cnt = 0;
   always @(posedge clk) e_cnt <= e_cnt + 1;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  tag;
      int          cyc;
   } exp_t;

   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  tag;
      logic [31:0] exp;
   } vec_t;

   exp_t        q[$];
   exp_t        cmp_ent;
   int          n_checks = 0;
   int          n_fail   = 0;
   int          busy_lo  = 1;
   int          busy_hi  = 0;
   int          last_e0  = 0;
   logic [31:0] last_res = '0;
   logic [4:0]  last_tag = '0;
   logic        cmp_busy;

   vec_t vecs [19] = '{
      '{OP_MUL,    32'h00000007, 32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB},
      '{OP_MULHU,  32'h80000000, 32'h80000000, 5'd2,  32'h40000000},
      '{OP_MULH,   32'h80000000, 32'h80000000, 5'd3,  32'h40000000},
      '{OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFF},
      '{OP_MULH,   32'hFFFFFFFF, 32'h00000001, 5'd5,  32'hFFFFFFFF},
      '{OP_DIV,    32'hFFFFFFF9, 32'h00000002, 5'd9,  32'hFFFFFFFD},
      '{OP_REM,    32'hFFFFFFF9, 32'h00000002, 5'd10, 32'hFFFFFFFF},
      '{OP_DIVU,   32'h00000007, 32'h00000002, 5'd11, 32'h00000003},
      '{OP_REMU,   32'h00000007, 32'h00000002, 5'd12, 32'h00000001},
      '{OP_DIVU,   32'h00000005, 32'h00000000, 5'd13, 32'hFFFFFFFF},
      '{OP_REM,    32'h00000005, 32'h00000000, 5'd14, 32'h00000005},
      '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000},
      '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h00000000},
      '{OP_MULHSU, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h80000000},
      '{OP_DIV,    32'h00000007, 32'hFFFFFFFE, 5'd18, 32'hFFFFFFFD},
      '{OP_REM,    32'h00000007, 32'hFFFFFFFE, 5'd19, 32'h00000001},
      '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd20, 32'hFFFFFFFE},
      '{OP_DIV,    32'h00000005, 32'h00000000, 5'd21, 32'hFFFFFFFF},
      '{OP_REMU,   32'h00000005, 32'h00000000, 5'd22, 32'h00000005}
   };

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h, expected %08h (edge %0d)", name, act, exp, e_cnt);
      end
   endtask

   // RISC-V M semantics with plain 64-bit arithmetic
   function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, p;
      logic [63:0] up;
      int          ia, ib;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      up = {32'h0, a} * {32'h0, b};
      ia = a;
      ib = b;
      case (op)
         OP_MUL:    return up[31:0];
         OP_MULH:   begin p = sa * sb; return p[63:32]; end
         OP_MULHSU: begin p = sa * longint'({32'h0, b}); return p[63:32]; end
         OP_MULHU:  return up[63:32];
         OP_DIV: begin
            if (b == 32'h0) return 32'hFFFFFFFF;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
            return ia / ib;
         end
         OP_DIVU:   return (b == 32'h0) ? 32'hFFFFFFFF : a / b;
         OP_REM: begin
            if (b == 32'h0) return a;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
            return ia % ib;
         end
         default:   return (b == 32'h0) ? a : a % b;
      endcase
   endfunction

   // Drive a request just after a falling edge; it meets the next rising edge.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input bit push);
      int   e0;
      bit   fast;
      exp_t ent;
      e0   = e_cnt + 1;
      fast = op[2] && (b == 32'h0 || (op[0] == 1'b0 && a == 32'h80000000 && b == 32'hFFFFFFFF));
      mif.start        = 1'b1;
      mif.op           = op;
      mif.operand_a    = a;
      mif.operand_b    = b;
      mif.dest_addr_in = tag;
      if (push) begin
         ent.res = model(op, a, b);
         ent.tag = tag;
         ent.cyc = fast ? e0 : e0 + XLEN + 1;
         q.push_back(ent);
      end
      busy_lo = e0;
      busy_hi = (fast || mif.flush) ? e0 - 1 : e0 + XLEN;
      last_e0 = e0;
      @(posedge clk);
      #1;
      mif.start = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 80; i++) begin
         if (q.size() == 0) return;
         @(negedge clk);
      end
      check("completion_timeout", q.size(), 0);
      q.delete();
   endtask

   // Compare process: every cycle, away from the active edge
   always @(negedge clk) begin
      if (rst) begin
         last_res = '0;
         last_tag = '0;
      end else begin
         cmp_busy = (e_cnt >= busy_lo) && (e_cnt <= busy_hi);
         check("busy", mif.busy, cmp_busy);
         if (mif.done) begin
            if (q.size() == 0) begin
               check("spurious_done", mif.done, 1'b0);
            end else begin
               cmp_ent = q.pop_front();
               check("result", mif.result, cmp_ent.res);
               check("dest_addr_out", mif.dest_addr_out, cmp_ent.tag);
               check("done_edge", e_cnt, cmp_ent.cyc);
               last_res = cmp_ent.res;
               last_tag = cmp_ent.tag;
            end
         end else begin
            check("result_hold", mif.result, last_res);
            check("dest_hold", mif.dest_addr_out, last_tag);
         end
      end
   end

   initial begin
      int e0;
      mif.start        = 1'b0;
      mif.op           = OP_MUL;
      mif.operand_a    = '0;
      mif.operand_b    = '0;
      mif.dest_addr_in = '0;
      mif.flush        = 1'b0;

      repeat (3) @(negedge clk);
      check("reset_busy",   mif.busy, 1'b0);
      check("reset_done",   mif.done, 1'b0);
      check("reset_result", mif.result, 32'h0);
      check("reset_dest",   mif.dest_addr_out, 5'd0);
      #2 rst = 1'b0;

      // Directed vectors: pin the model to the hand values, then run the DUT
      for (int i = 0; i < 19; i++) begin
         check($sformatf("model_vec%0d", i), model(vecs[i].op, vecs[i].a, vecs[i].b), vecs[i].exp);
         @(negedge clk);
         issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, 1'b1);
         wait_idle();
      end

      // Back-to-back: second request issued in the cycle done is high
      check("model_mul6x7", model(OP_MUL, 32'd6, 32'd7), 32'h0000002A);
      @(negedge clk);
      issue(OP_MUL, 32'd6, 32'd7, 5'd3, 1'b1);
      e0 = last_e0;
      while (e_cnt != e0 + XLEN + 1) @(negedge clk);
      issue(OP_DIVU, 32'd100, 32'd7, 5'd4, 1'b1);
      wait_idle();

      // Flush beats a same-cycle start
      @(negedge clk);
      mif.flush = 1'b1;
      issue(OP_DIVU, 32'd50, 32'd5, 5'd25, 1'b0);
      mif.flush = 1'b0;
      repeat (3) @(negedge clk);

      // Ignored start while busy, then flush mid-divide
      @(negedge clk);
      issue(OP_DIV, 32'd1000, 32'd3, 5'd7, 1'b0);
      e0 = last_e0;
      while (e_cnt != e0 + 4) @(negedge clk);
      mif.start        = 1'b1;
      mif.op           = OP_DIVU;
      mif.operand_a    = 32'd55;
      mif.operand_b    = 32'd5;
      mif.dest_addr_in = 5'd30;
      @(posedge clk);
      #1 mif.start = 1'b0;
      while (e_cnt != e0 + 9) @(negedge clk);
      busy_hi   = e0 + 9;
      mif.flush = 1'b1;
      @(posedge clk);
      #1 mif.flush = 1'b0;
      check("flush_busy", mif.busy, 1'b0);
      check("flush_done", mif.done, 1'b0);
      repeat (3) @(negedge clk);
      check("model_divu100_7", model(OP_DIVU, 32'd100, 32'd7), 32'h0000000E);
      issue(OP_DIVU, 32'd100, 32'd7, 5'd8, 1'b1);
      wait_idle();

      // Asynchronous reset in the middle of a multiply
      @(negedge clk);
      issue(OP_MUL, 32'd5, 32'd5, 5'd6, 1'b0);
      e0 = last_e0;
      while (e_cnt != e0 + 5) @(negedge clk);
      #2;
      busy_hi = busy_lo - 1;
      rst     = 1'b1;
      #1;
      check("async_rst_busy",   mif.busy, 1'b0);
      check("async_rst_done",   mif.done, 1'b0);
      check("async_rst_result", mif.result, 32'h0);
      check("async_rst_dest",   mif.dest_addr_out, 5'd0);
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check("model_mul3x4", model(OP_MUL, 32'd3, 32'd4), 32'h0000000C);
      issue(OP_MUL, 32'd3, 32'd4, 5'd2, 1'b1);
      wait_idle();

      repeat (3) @(negedge clk);
      check("queue_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Hard bound on simulated time
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Iterative RV32M multiply/divide unit for the EX stage, generalised to XLEN-bit operands. It runs alongside the single-cycle ALU and takes one op per start handshake. It computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU serially, one bit per cycle, and holds the pipeline via busy until a one-cycle done pulse. Divide-by-zero and signed overflow take a 1-cycle fast path.

Parameters:
XLEN, 32, operand/result width (>=8, power of 2)
CNT_W, $clog2(XLEN), iteration counter width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  request; accepted only when busy=0
op  in  3  M-ext funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
operand_a  in  XLEN  rs1 value / dividend
operand_b  in  XLEN  rs2 value / divisor
dest_addr_in  in  5  destination register tag
flush  in  1  abort in-flight op (branch/jump redirect)
busy  out  1  op in flight; drives EX stall
done  out  1  one-cycle pulse, result valid
result  out  XLEN  result, held until next done
dest_addr_out  out  5  tag of completed op, held with result

Behaviour:
- Reset (async): state IDLE, busy=0, done=0, result=0, dest_addr_out=0, counter=0, internal regs cleared. Reset mid-op drops the op immediately; no done.
- States: IDLE, CALC, FIN. busy = (state != IDLE). done is registered.
- IDLE: if start && !flush at edge E0:
  - Fast path (divide op with b==0, or DIV/REM with a==MIN_INT, b==all-ones): at E0 register result and tag, done=1; stay IDLE. done is visible in the cycle after E0.
  - Otherwise latch |a|, |b| (sign per op), negate flags, op, tag; counter=0; go CALC.
- CALC: one iteration per edge.
  - Multiply: shift-add into a 2*XLEN product.
  - Divide: restoring, 1 quotient bit per edge.
  - After XLEN iterations (edges E1..E_XLEN) go FIN.
- FIN: at E_(XLEN+1) apply sign correction and select low/high half or quotient/remainder; register result, dest_addr_out, done=1; go IDLE. Total: done high in the cycle after E_(XLEN+1) (E33 for XLEN=32).
- done is deasserted on every edge except the completion edge.
- Back-to-back: a start is accepted in the cycle done is high, since state is IDLE.
- start while busy: ignored, no queuing.
- flush: synchronous; at an edge with flush=1, state returns to IDLE and done=0. result/dest_addr_out are unchanged. flush beats start in the same cycle. flush in the done cycle does not retract that done.
- Arithmetic (RISC-V M semantics):
  - MUL: low XLEN bits. MULH: high XLEN bits, signed x signed. MULHSU: high XLEN bits, signed a x unsigned b. MULHU: high XLEN bits, unsigned x unsigned.
  - DIV/REM: quotient truncates toward zero; remainder takes the sign of the dividend.
  - Divide by zero: quotient = all-ones (DIV and DIVU), remainder = a.
  - Overflow MIN/-1: DIV = MIN, REM = 0.
- Signed magnitudes use XLEN+1-bit intermediates so MIN_INT negation is exact. Product negation is over 2*XLEN bits.

Decomposition:
- Shared encodings header: M-ext funct3 constants (MUL..REMU) and FSM state encodings IDLE/CALC/FIN.
- One natural sub-module, muldiv_iter_step: combinational single-iteration datapath (add-shift / trial-subtract), instantiated once. FSM, counter and sign logic stay in ex_muldiv_unit.

Test Plan:
- MUL a=00000007, b=FFFFFFFD, start at E0 -> busy E0..E32, done only in cycle after E33, result=FFFFFFEB; MULHU a=b=80000000 -> 40000000.
- MULH a=b=80000000 -> 40000000; MULHSU a=FFFFFFFF, b=FFFFFFFF -> FFFFFFFF; MULH a=FFFFFFFF, b=00000001 -> FFFFFFFF.
- DIV a=FFFFFFF9 (-7), b=2 -> FFFFFFFD; REM same -> FFFFFFFF; DIVU 7/2 -> 3; REMU 7/2 -> 1; dest_addr_in=5'd9 -> dest_addr_out=9 at done.
- Fast path: DIVU 5/0 -> FFFFFFFF, done the cycle after E0, busy never high; REM 5/0 -> 5; DIV 80000000/FFFFFFFF -> 80000000; REM same -> 0.
- Start a DIV, pulse start with different operands at cycle 5 (ignored), assert flush at cycle 10 -> busy=0 next cycle, no done, result unchanged. A new DIVU 100/7 then gives 0000000E with full latency.
- Assert rst asynchronously mid-CALC (between edges) -> busy, done, result, dest_addr_out all 0 immediately. After release, MUL 3*4 -> 0000000C.
